// File: rtl/typhoon_video_pkg.sv
// Shared video constants and types for the scan-out path.
//   H_ACTIVE / V_ACTIVE / V_TOTAL : raster geometry (visible pixels, visible
//                                   lines, total lines per frame)
//   pixel_t      : one 16-bit framebuffer word
//   sram_addr_t  : 20-bit SRAM word address
//   fetch_state_t: line prefetch FSM states
package typhoon_video_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    typedef logic [15:0] pixel_t;
    typedef logic [19:0] sram_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/line_buffer_dp.sv
// Ping-pong line buffer: simple dual-port RAM holding two banks of H_ACTIVE
// pixel words. Bank b occupies entries b*H_ACTIVE .. b*H_ACTIVE+H_ACTIVE-1.
//   clk      : clock
//   wr_en    : write strobe
//   wr_bank  : bank being filled
//   wr_idx   : word index within the bank
//   wr_data  : word to store
//   rd_en    : read strobe (read data registered)
//   rd_bank  : bank being displayed
//   rd_idx   : word index within the bank (must be < H_ACTIVE when rd_en)
//   rd_data  : registered read word, updated only when rd_en
module line_buffer_dp
    import typhoon_video_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic       wr_bank,
    input  logic [9:0] wr_idx,
    input  pixel_t     wr_data,
    input  logic       rd_en,
    input  logic       rd_bank,
    input  logic [9:0] rd_idx,
    output pixel_t     rd_data
);

    localparam int DEPTH = 2 * H_ACTIVE;

    pixel_t     mem [0:DEPTH-1];
    logic [10:0] wr_addr;
    logic [10:0] rd_addr;

    // Bank offset instead of a bank-bit concatenation keeps the array at
    // exactly two lines deep.
    assign wr_addr = wr_bank ? (11'(wr_idx) + 11'(H_ACTIVE)) : 11'(wr_idx);
    assign rd_addr = rd_bank ? (11'(rd_idx) + 11'(H_ACTIVE)) : 11'(rd_idx);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/scanout_line_prefetch.sv
// Framebuffer scan-out line prefetcher. While line y is displayed, line y+1
// is fetched from SRAM into the idle half of a ping-pong line buffer; pixel
// strobes read the displayed half with one clock of latency.
// Optional build macro SCANOUT_LOWRES_EN: 320x240 pixel-doubled mode (half
// line fetch/stride, DrawX>>1 read index, fetch/bank swap on even lines only).
//   Clk         : system clock
//   Reset_N     : asynchronous active-low reset
//   pix_en      : one-cycle pixel strobe
//   DrawX/DrawY : current scan position
//   frame_base  : SRAM word address of pixel (0,0), sampled at a line-0 fetch
//   rd_req/rd_addr/rd_ack/rd_data : SRAM read handshake (data valid with ack)
//   pixel_data  : pixel word for the previous strobe
//   pixel_valid : one-cycle pulse one clock after pix_en
//   fetch_busy  : a line fetch is in progress
//   underrun    : sticky, a fetch was aborted by the next line trigger
module scanout_line_prefetch
    import typhoon_video_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        pix_en,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [19:0] frame_base,
    output logic        rd_req,
    output logic [19:0] rd_addr,
    input  logic        rd_ack,
    input  logic [15:0] rd_data,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        fetch_busy,
    output logic        underrun
);

`ifdef SCANOUT_LOWRES_EN
    localparam int FETCH_WORDS = H_ACTIVE / 2;
`else
    localparam int FETCH_WORDS = H_ACTIVE;
`endif
    localparam logic [9:0] LAST_IDX = 10'(FETCH_WORDS - 1);
    localparam sram_addr_t STRIDE   = 20'(FETCH_WORDS);

    fetch_state_t state_reg;
    logic [9:0]   prev_y_reg;
    logic [9:0]   cnt_reg;
    sram_addr_t   line_addr_reg;
    logic         disp_bank_reg;
    logic         fill_bank_reg;
    logic         pix_zero_reg;

    logic         trigger;
    logic [9:0]   target;
    logic         qualify;
    logic         toggle;
    logic         disp_bank_next;
    sram_addr_t   line_addr_next;
    logic         in_range;
    logic [9:0]   rd_idx;
    logic         wr_en;
    pixel_t       ram_q;

    // A line trigger is any change of DrawY; prev_y resets to an impossible
    // value so the first sampled line after reset always triggers.
    assign trigger = (DrawY != prev_y_reg);
    assign target  = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : (DrawY + 10'd1);

`ifdef SCANOUT_LOWRES_EN
    // Each buffered line serves two scan lines: fetch only ahead of even
    // targets and swap banks only when an even line starts.
    assign qualify = trigger && (target < 10'(V_ACTIVE)) && !target[0];
    assign toggle  = trigger && !DrawY[0];
    assign rd_idx  = {1'b0, DrawX[9:1]};
`else
    assign qualify = trigger && (target < 10'(V_ACTIVE));
    assign toggle  = trigger;
    assign rd_idx  = DrawX;
`endif

    assign disp_bank_next = toggle ? ~disp_bank_reg : disp_bank_reg;

    // Line address advances by one stride per fetched line; line 0 reloads
    // the frame base, so no multiplier is needed. 20-bit arithmetic wraps.
    assign line_addr_next = (target == 10'd0) ? frame_base : (line_addr_reg + STRIDE);

    assign in_range = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));

    // Acks are honoured only with a request outstanding.
    assign wr_en = rd_req && rd_ack;

    line_buffer_dp u_line_buffer (
        .clk     (Clk),
        .wr_en   (wr_en),
        .wr_bank (fill_bank_reg),
        .wr_idx  (cnt_reg),
        .wr_data (rd_data),
        .rd_en   (pix_en && in_range),
        .rd_bank (disp_bank_reg),
        .rd_idx  (rd_idx),
        .rd_data (ram_q)
    );

    // Fetch FSM with registered request/address/status outputs.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_reg     <= IDLE;
            prev_y_reg    <= 10'h3FF;
            cnt_reg       <= 10'd0;
            line_addr_reg <= 20'd0;
            disp_bank_reg <= 1'b0;
            fill_bank_reg <= 1'b0;
            rd_req        <= 1'b0;
            rd_addr       <= 20'd0;
            fetch_busy    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            if (trigger) begin
                prev_y_reg    <= DrawY;
                disp_bank_reg <= disp_bank_next;
                // A new line arriving mid-fetch means the fetch lost the race.
                if (state_reg == FETCH) begin
                    underrun <= 1'b1;
                end
                if (qualify) begin
                    state_reg     <= FETCH;
                    line_addr_reg <= line_addr_next;
                    rd_addr       <= line_addr_next;
                    cnt_reg       <= 10'd0;
                    fill_bank_reg <= ~disp_bank_next;
                    rd_req        <= 1'b1;
                    fetch_busy    <= 1'b1;
                end else begin
                    state_reg  <= IDLE;
                    rd_req     <= 1'b0;
                    fetch_busy <= 1'b0;
                end
            end else if ((state_reg == FETCH) && rd_ack) begin
                cnt_reg <= cnt_reg + 10'd1;
                rd_addr <= rd_addr + 20'd1;
                if (cnt_reg == LAST_IDX) begin
                    state_reg  <= IDLE;
                    rd_req     <= 1'b0;
                    fetch_busy <= 1'b0;
                end
            end
        end
    end

    // Pixel path: the RAM read register holds the word; a registered flag
    // forces zero for off-screen strobes and for the reset value.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            pixel_valid  <= 1'b0;
            pix_zero_reg <= 1'b1;
        end else begin
            pixel_valid <= pix_en;
            if (pix_en) begin
                pix_zero_reg <= !in_range;
            end
        end
    end

    assign pixel_data = pix_zero_reg ? 16'h0000 : ram_q;

endmodule

// File: tb/tb_scanout_line_prefetch.sv
module tb_scanout_line_prefetch;

    logic        Clk;
    logic        Reset_N;
    logic        pix_en;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [19:0] frame_base;
    logic        rd_req;
    logic [19:0] rd_addr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        fetch_busy;
    logic        underrun;

`ifdef SCANOUT_LOWRES_EN
    localparam int W = 320;
`else
    localparam int W = 640;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ack_mode = 0;          // 0: never ack, 1: every cycle, 2: every 2nd cycle
    logic ack_phase = 1'b0;

    logic [19:0] addr_q [$];   // expected SRAM request addresses, in order
    logic [15:0] pix_q  [$];   // expected pixel words, in order

    scanout_line_prefetch dut (
        .Clk         (Clk),
        .Reset_N     (Reset_N),
        .pix_en      (pix_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_base  (frame_base),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .fetch_busy  (fetch_busy),
        .underrun    (underrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // SRAM model (mem[a] = a[15:0]) plus request and pixel scoreboards.
    initial begin
        rd_ack  = 1'b0;
        rd_data = 16'h0000;
        forever begin
            @(negedge Clk);
            ack_phase = ~ack_phase;
            if (rd_req && (ack_mode == 1 || (ack_mode == 2 && ack_phase))) begin
                rd_ack  = 1'b1;
                rd_data = rd_addr[15:0];
                if (addr_q.size() == 0)
                    chk("rd_req_unexpected", {31'd0, rd_req}, 32'd0);
                else
                    chk("rd_addr", {12'd0, rd_addr}, {12'd0, addr_q.pop_front()});
            end else begin
                rd_ack  = 1'b0;
                rd_data = 16'hDEAD;
            end
            if (pixel_valid) begin
                if (pix_q.size() == 0)
                    chk("pixel_valid_unexpected", {31'd0, pixel_valid}, 32'd0);
                else
                    chk("pixel_data", {16'd0, pixel_data}, {16'd0, pix_q.pop_front()});
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Drive a new scan line and queue the addresses its fetch should request.
    task automatic step_y(input logic [9:0] y, input int words, input logic [19:0] base);
        DrawY = y;
        for (int i = 0; i < words; i++) addr_q.push_back(base + 20'(i));
        @(negedge Clk);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        @(negedge Clk);
        while (fetch_busy && n < max_cyc) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_busy_fall"}, {31'd0, fetch_busy}, 32'd0);
        chk({tag, "_words_left"}, addr_q.size(), 32'd0);
        addr_q.delete();
    endtask

    task automatic pix(input logic [9:0] x, input logic [15:0] exp, input string tag);
        DrawX  = x;
        pix_en = 1'b1;
        pix_q.push_back(exp);
        @(negedge Clk);
        pix_en = 1'b0;
        chk({tag, "_valid"}, {31'd0, pixel_valid}, 32'd1);
        @(negedge Clk);
        chk({tag, "_valid_pulse"}, {31'd0, pixel_valid}, 32'd0);
    endtask

    initial begin
        int n;
        Reset_N    = 1'b0;
        pix_en     = 1'b0;
        DrawX      = 10'd0;
        DrawY      = 10'd523;
        frame_base = 20'h10000;
        repeat (3) @(negedge Clk);

        chk("rst_rd_req",      {31'd0, rd_req},      32'd0);
        chk("rst_rd_addr",     {12'd0, rd_addr},     32'd0);
        chk("rst_pixel_data",  {16'd0, pixel_data},  32'd0);
        chk("rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
        chk("rst_fetch_busy",  {31'd0, fetch_busy},  32'd0);
        chk("rst_underrun",    {31'd0, underrun},    32'd0);

        Reset_N = 1'b1;
        repeat (4) @(negedge Clk);
        chk("no_fetch_target_524", {31'd0, rd_req}, 32'd0);

`ifdef SCANOUT_LOWRES_EN
        ack_mode = 1;
        step_y(10'd524, W, 20'h10000);
        wait_idle(2000, "lr_line0");
        step_y(10'd0, 0, 20'h0);
        repeat (2) @(negedge Clk);
        chk("lr_no_fetch_odd_target", {31'd0, rd_req}, 32'd0);
        pix(10'd7, 16'h0003, "lr_y0_x7");
        step_y(10'd1, W, 20'h10140);
        wait_idle(2000, "lr_line1");
        step_y(10'd2, 0, 20'h0);
        repeat (2) @(negedge Clk);
        chk("lr_no_fetch_target3", {31'd0, rd_req}, 32'd0);
        pix(10'd7, 16'h0143, "lr_y2_x7");
        pix(10'd6, 16'h0143, "lr_y2_x6");
        chk("lr_underrun", {31'd0, underrun}, 32'd0);
`else
        // Line 0 prefetch from frame_base, ack every cycle
        ack_mode = 1;
        step_y(10'd524, W, 20'h10000);
        wait_idle(2000, "line0");

        // Line 1 prefetch with ack every 2nd cycle, while line 0 is displayed
        ack_mode = 2;
        step_y(10'd0, W, 20'h10280);
        pix(10'd5, 16'h0005, "y0_x5");
        wait_idle(3000, "line1");
        chk("line1_underrun", {31'd0, underrun}, 32'd0);

        ack_mode = 1;
        step_y(10'd1, W, 20'h10500);
        wait_idle(2000, "line2");
        step_y(10'd2, W, 20'h10780);
        pix(10'd639, 16'h077F, "y2_x639");
        pix(10'd0,   16'h0500, "y2_x0");
        wait_idle(2000, "line3");
        for (int y = 3; y < 10; y++) begin
            step_y(10'(y), W, 20'h10000 + 20'((y + 1) * 640));
            wait_idle(2000, "line_step");
        end

        // Overrun: stall line 11 fetch, then advance to line 11
        ack_mode = 0;
        step_y(10'd10, 0, 20'h0);
        repeat (3) @(negedge Clk);
        chk("stall_rd_req",   {31'd0, rd_req},   32'd1);
        chk("stall_rd_addr",  {12'd0, rd_addr},  32'h11B80);
        chk("stall_underrun", {31'd0, underrun}, 32'd0);
        step_y(10'd11, W, 20'h11E00);
        chk("overrun_underrun", {31'd0, underrun},   32'd1);
        chk("overrun_rd_addr",  {12'd0, rd_addr},    32'h11E00);
        chk("overrun_busy",     {31'd0, fetch_busy}, 32'd1);
        ack_mode = 1;
        wait_idle(2000, "line12");

        // Off-screen pixels and non-qualifying targets
        step_y(10'd12, W, 20'h12080);
        wait_idle(2000, "line13");
        pix(10'd700, 16'h0000, "x700");
        step_y(10'd479, 0, 20'h0);
        repeat (3) @(negedge Clk);
        chk("no_fetch_target_480", {31'd0, rd_req}, 32'd0);
        step_y(10'd490, 0, 20'h0);
        pix(10'd5, 16'h0000, "y490");
        chk("no_fetch_target_491", {31'd0, rd_req}, 32'd0);
        step_y(10'd523, 0, 20'h0);
        repeat (2) @(negedge Clk);
        chk("no_fetch_target_524b", {31'd0, rd_req},   32'd0);
        chk("underrun_sticky",      {31'd0, underrun}, 32'd1);

        // Reset in the middle of a line-0 fetch
        step_y(10'd524, W, 20'h10000);
        n = 0;
        while (addr_q.size() > W - 100 && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        chk("fetch_reached_word100", {31'd0, addr_q.size() <= W - 100}, 32'd1);
        #2 Reset_N = 1'b0;
        #1;
        chk("async_rst_rd_req",      {31'd0, rd_req},      32'd0);
        chk("async_rst_rd_addr",     {12'd0, rd_addr},     32'd0);
        chk("async_rst_busy",        {31'd0, fetch_busy},  32'd0);
        chk("async_rst_underrun",    {31'd0, underrun},    32'd0);
        chk("async_rst_pixel_data",  {16'd0, pixel_data},  32'd0);
        chk("async_rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
        addr_q.delete();
        frame_base = 20'hFFF00;
        repeat (2) @(negedge Clk);
        chk("held_rst_rd_req", {31'd0, rd_req}, 32'd0);

        // Release: first sampled DrawY (524) prefetches line 0 at a base
        // whose line wraps across 2^20.
        Reset_N = 1'b1;
        for (int i = 0; i < W; i++) addr_q.push_back(20'hFFF00 + 20'(i));
        #1;
        chk("release_no_req", {31'd0, rd_req}, 32'd0);
        @(negedge Clk);
        chk("release_first_req", {31'd0, rd_req}, 32'd1);
        wait_idle(2000, "wrap_line0");
        step_y(10'd0, W, 20'h00180);
        pix(10'd5,   16'hFF05, "wrap_x5");
        pix(10'd300, 16'h002C, "wrap_x300");
        wait_idle(2000, "wrap_line1");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scanout_line_prefetch.md
Name: scanout_line_prefetch

Overview:
- Framebuffer scan-out stage between the SRAM controller and the VGA output path.
- During display of line y, fetches line y+1 from SRAM into a ping-pong line buffer, one 16-bit word per pixel.
- Using the VGA timing generator's DrawX/DrawY, returns a registered pixel word for every pixel strobe.

Parameters:
- H_ACTIVE, 640: visible pixels per line; also the words fetched per line and the SRAM line stride.
- V_ACTIVE, 480: visible lines.
- V_TOTAL, 525: total lines per frame; line V_TOTAL-1 prefetches line 0.

Ports:
- Clk  in  1  system clock.
- Reset_N  in  1  reset, asynchronous assert, active-low.
- pix_en  in  1  one-cycle pixel strobe, synchronous to Clk.
- DrawX  in  10  current scan x.
- DrawY  in  10  current scan y.
- frame_base  in  20  SRAM word address of pixel (0,0); sampled when a line-0 fetch starts.
- rd_req  out  1  SRAM read request.
- rd_addr  out  20  SRAM word address.
- rd_ack  in  1  request accepted; rd_data is valid in the same cycle.
- rd_data  in  16  SRAM read word.
- pixel_data  out  16  pixel word for the previous strobe.
- pixel_valid  out  1  one-cycle pulse, 1 clock after pix_en.
- fetch_busy  out  1  FETCH state active.
- underrun  out  1  sticky; a fetch was aborted before completion.

Behaviour:
- Reset values: rd_req=0, rd_addr=0, pixel_data=0, pixel_valid=0, fetch_busy=0, underrun=0, disp_bank=0, prev_y=10'h3FF, state=IDLE.
- Line trigger: DrawY != prev_y, sampled every Clk. On trigger:
  - prev_y<=DrawY and disp_bank toggles.
  - target = (DrawY==V_TOTAL-1) ? 0 : DrawY+1.
  - A fetch starts only if target < V_ACTIVE; fill bank = ~disp_bank.
- Line address, no multiplier:
  - target==0: line_addr<=frame_base.
  - Otherwise: line_addr<=line_addr+H_ACTIVE.
  - Arithmetic is 20-bit modulo, wrapping at 2^20.
- FSM, IDLE/FETCH:
  - IDLE→FETCH on a qualifying trigger. cnt=0, rd_addr=line_addr.
  - FETCH: rd_req=1, with rd_addr stable until rd_ack.
  - On rd_ack: write rd_data to buf[fill][cnt], then cnt++ and rd_addr++.
  - On rd_ack with cnt==H_ACTIVE-1: go to IDLE and drop rd_req in the next cycle.
  - One request outstanding at most; rd_ack while rd_req=0 is ignored.
- Trigger while in FETCH (overrun):
  - Set underrun and abort the current fetch.
  - In the same cycle, restart FETCH for the new target with cnt=0, or go to IDLE if the new target is ≥V_ACTIVE.
- Pixel path:
  - On pix_en: pixel_data <= (DrawX<H_ACTIVE && DrawY<V_ACTIVE) ? buf[disp_bank][DrawX] : 16'h0000.
  - pixel_valid <= pix_en.
  - Latency is exactly 1 Clk.
- Simultaneous buffer write and read: always different banks, so no hazard.
- Reset asserted mid-fetch: all state clears asynchronously, rd_req=0 immediately, underrun=0.
- After reset release: the first DrawY sample fires a trigger (prev_y=3FF). The display bank holds undefined data until the first full fetch; this is acceptable.

Optional Feature:
- Macro: SCANOUT_LOWRES_EN.
- Defined, 320x240 pixel-doubled mode:
  - Fetch count and line stride become H_ACTIVE/2.
  - Read index is DrawX>>1.
  - Triggers qualify only when target is even; the fetched line is target>>1.
  - disp_bank toggles only on even DrawY.
- Undefined: full-resolution behaviour as above.

Decomposition:
- Package typhoon_video_pkg:
  - H_ACTIVE, V_ACTIVE, V_TOTAL constants.
  - pixel_t (logic[15:0]) and sram_addr_t (logic[19:0]).
  - fetch_state_t enum {IDLE, FETCH}.
- Sub-module line_buffer_dp:
  - Simple dual-port RAM, 2*H_ACTIVE x 16.
  - Write port {bank, cnt}; registered read port {bank, x}.

Test Plan:
1. frame_base=20'h10000; memory model mem[a]=a[15:0]; rd_ack every cycle; step DrawY 523→524→0; on DrawY=0, pix_en with DrawX=5.
   - Fetch addresses are 10000..1027F.
   - pixel_data=16'h0005 one clock later, pixel_valid=1.
2. DrawY 0→1 with ack every 2nd cycle.
   - 640 requests at 10280..104FF.
   - fetch_busy falls before the next trigger; underrun stays 0.
   - Pixel at DrawY=2, DrawX=639 returns 16'h077F.
3. Hold rd_ack=0 and step DrawY 10→11.
   - underrun=1.
   - rd_addr jumps to the line-12 base 10000+12*640=11E00 with cnt=0.
4. DrawX=700 or DrawY=490 with pix_en.
   - pixel_data=0, pixel_valid=1.
   - No fetch is started for targets 480..523.
5. Reset_N low after word 100 of a fetch.
   - rd_req=0 without waiting for a clock edge; all outputs at reset values.
   - After release, no request until the first sampled DrawY.
6. With SCANOUT_LOWRES_EN, step DrawY 1→2.
   - 320 reads from base+320.
   - DrawX=7 and DrawX=6 both return mem[base+323].
   - No fetch is triggered on DrawY 2→3.
